// File: rtl/pcma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcma_pkg
// Purpose  : Shared constants, gain table and helpers for the ADPCM-A mixer.
// Revision : 1.0 - initial release
// ============================================================================
package pcma_pkg;

    localparam int NCH    = 6;
    localparam int SAMP_W = 16;
    localparam int ACC_W  = 19;
    localparam int GAIN_W = 9;
    localparam int VP_W   = 8;

    // 0.75 dB steps within one octave, Q8
    localparam logic [GAIN_W-1:0] GAIN [8] = '{
        9'd256, 9'd235, 9'd215, 9'd197, 9'd181, 9'd166, 9'd152, 9'd140
    };

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    function automatic logic signed [SAMP_W-1:0] ch_sample(
        input logic [NCH*SAMP_W-1:0] v,
        input int unsigned           i
    );
        return v[i*SAMP_W +: SAMP_W];
    endfunction

    function automatic logic [VP_W-1:0] ch_volpan(
        input logic [NCH*VP_W-1:0] v,
        input int unsigned         i
    );
        return v[i*VP_W +: VP_W];
    endfunction

    function automatic logic signed [SAMP_W-1:0] sat_samp(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [SAMP_W-1:0] r;
        if (a > SAT_MAX)
            r = SAT_MAX[SAMP_W-1:0];
        else if (a < SAT_MIN)
            r = SAT_MIN[SAMP_W-1:0];
        else
            r = a[SAMP_W-1:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcma_atten.sv
`default_nettype none
// ============================================================================
// Module   : pcma_atten
// Purpose  : Combinational level attenuator: instrument + total level to a
//            floor-rounded scaled sample.
// Revision : 1.0 - initial release
// ============================================================================
module pcma_atten
    import pcma_pkg::*;
(
    input  logic signed [SAMP_W-1:0] i_sample,
    input  logic        [4:0]        i_il,
    input  logic        [5:0]        i_tl,
    output logic signed [SAMP_W-1:0] o_p
);

    logic        [6:0]             w_att;
    logic signed [GAIN_W:0]        w_mant;
    logic signed [SAMP_W+GAIN_W:0] w_prod;
    logic signed [SAMP_W+GAIN_W:0] w_scaled;

    // 31-IL and 63-TL are just the bitwise inverses
    assign w_att    = {2'b00, ~i_il} + {1'b0, ~i_tl};
    assign w_mant   = signed'({1'b0, GAIN[w_att[2:0]]});
    assign w_prod   = i_sample * w_mant;
    assign w_scaled = (w_prod >>> 8) >>> w_att[6:3];
    assign o_p      = SAMP_W'(w_scaled);

endmodule
`default_nettype wire

// File: rtl/pcma_mix.sv
`default_nettype none
// ============================================================================
// Module   : pcma_mix
// Purpose  : Time-multiplexed six-channel ADPCM-A level/pan mixer producing a
//            saturated 16-bit stereo pair once per sample strobe.
// Revision : 1.0 - initial release
// ============================================================================
module pcma_mix
    import pcma_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CLK_SAMP,
    input  logic [NCH*SAMP_W-1:0]   SAMPLE_IN,
    input  logic [NCH*VP_W-1:0]     VOLPAN,
    input  logic [5:0]              TOTAL_LEVEL,
    input  logic [NCH-1:0]          CH_MASK,
    output logic [SAMP_W-1:0]       LEFT_OUT,
    output logic [SAMP_W-1:0]       RIGHT_OUT,
    output logic                    OUT_VALID,
    output logic                    BUSY
);

    localparam int CNT_W = $clog2(NCH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NCH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [NCH*SAMP_W-1:0]    r_samp;
    logic [NCH*VP_W-1:0]      r_volpan;
    logic [5:0]               r_tl;
    logic [NCH-1:0]           r_mask;
    logic signed [SAMP_W-1:0] r_p;
    logic                     r_pl;
    logic                     r_pr;
    logic                     r_pv;
    logic signed [ACC_W-1:0]  r_lacc;
    logic signed [ACC_W-1:0]  r_racc;
    logic [SAMP_W-1:0]        r_left;
    logic [SAMP_W-1:0]        r_right;
    logic                     r_valid;
    logic                     r_busy;

    logic signed [SAMP_W-1:0] w_samp;
    logic [VP_W-1:0]          w_vp;
    logic signed [SAMP_W-1:0] w_p;
    logic                     w_unused_rsvd;

    assign w_samp        = ch_sample(r_samp, 32'(r_cnt));
    assign w_vp          = ch_volpan(r_volpan, 32'(r_cnt));
    assign w_unused_rsvd = w_vp[5];

    pcma_atten u_atten (
        .i_sample (w_samp),
        .i_il     (w_vp[4:0]),
        .i_tl     (r_tl),
        .o_p      (w_p)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_samp   <= '0;
            r_volpan <= '0;
            r_tl     <= '0;
            r_mask   <= '0;
            r_p      <= '0;
            r_pl     <= 1'b0;
            r_pr     <= 1'b0;
            r_pv     <= 1'b0;
            r_lacc   <= '0;
            r_racc   <= '0;
            r_left   <= '0;
            r_right  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_pv    <= 1'b0;
            // accumulate trails the multiply stage by one edge
            if (r_pv) begin
                if (r_pl) r_lacc <= r_lacc + ACC_W'(r_p);
                if (r_pr) r_racc <= r_racc + ACC_W'(r_p);
            end
            case (r_state)
                S_IDLE: begin
                    if (CLK_SAMP) begin
                        r_samp   <= SAMPLE_IN;
                        r_volpan <= VOLPAN;
                        r_tl     <= TOTAL_LEVEL;
                        r_mask   <= CH_MASK;
                        r_lacc   <= '0;
                        r_racc   <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_p   <= r_mask[r_cnt] ? w_p : '0;
                    r_pl  <= w_vp[7];
                    r_pr  <= w_vp[6];
                    r_pv  <= 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_left  <= sat_samp(r_lacc);
                    r_right <= sat_samp(r_racc);
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign LEFT_OUT  = r_left;
    assign RIGHT_OUT = r_right;
    assign OUT_VALID = r_valid;
    assign BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pcma_mix.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcma_mix
// Purpose  : Scoreboard bench for pcma_mix: reference mix model, directed level
//            and saturation cases, strobe overlap, mid-mix reset, random mixes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcma_mix;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CLK_SAMP = 1'b0;
    logic [95:0] SAMPLE_IN = '0;
    logic [47:0] VOLPAN = '0;
    logic [5:0]  TOTAL_LEVEL = '0;
    logic [5:0]  CH_MASK = '0;
    logic [15:0] LEFT_OUT;
    logic [15:0] RIGHT_OUT;
    logic        OUT_VALID;
    logic        BUSY;

    pcma_mix dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CLK_SAMP    (CLK_SAMP),
        .SAMPLE_IN   (SAMPLE_IN),
        .VOLPAN      (VOLPAN),
        .TOTAL_LEVEL (TOTAL_LEVEL),
        .CH_MASK     (CH_MASK),
        .LEFT_OUT    (LEFT_OUT),
        .RIGHT_OUT   (RIGHT_OUT),
        .OUT_VALID   (OUT_VALID),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   gain_t[8] = '{256, 235, 215, 197, 181, 166, 152, 140};

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mix_model(input logic [95:0] s, input logic [47:0] vp,
                                              input logic [5:0] tl, input logic [5:0] m);
        int l = 0;
        int r = 0;
        for (int ch = 0; ch < 6; ch++) begin
            int smp;
            int il;
            int att;
            int p;
            smp = int'($signed(s[ch*16 +: 16]));
            il  = int'(vp[ch*8 +: 5]);
            att = (31 - il) + (63 - int'(tl));
            p   = (smp * gain_t[att % 8]) >>> 8;
            p   = p >>> (att / 8);
            if (!m[ch]) p = 0;
            if (vp[ch*8+7]) l += p;
            if (vp[ch*8+6]) r += p;
        end
        if (l > 32767) l = 32767;
        if (l < -32768) l = -32768;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return {l[15:0], r[15:0]};
    endfunction

    // every OUT_VALID must match the oldest pending strobe, on time
    always @(negedge CLK) begin
        if (!RESET && OUT_VALID) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("mix_left", {16'h0, LEFT_OUT}, {16'h0, e.l});
                check_val("mix_right", {16'h0, RIGHT_OUT}, {16'h0, e.r});
                check_val("latency", cyc, e.cyc);
                check_val("busy_at_out", {31'h0, BUSY}, 32'd0);
            end
        end
    end

    task automatic do_mix(input logic [95:0] s, input logic [47:0] vp,
                          input logic [5:0] tl, input logic [5:0] m);
        exp_t e;
        logic [31:0] lr;
        @(negedge CLK);
        SAMPLE_IN   = s;
        VOLPAN      = vp;
        TOTAL_LEVEL = tl;
        CH_MASK     = m;
        CLK_SAMP    = 1'b1;
        lr    = mix_model(s, vp, tl, m);
        e.l   = lr[31:16];
        e.r   = lr[15:0];
        e.cyc = cyc + 9;
        sb.push_back(e);
        @(negedge CLK);
        CLK_SAMP = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) begin
            check_val("out_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic run_expect(input string tag, input logic [95:0] s, input logic [47:0] vp,
                              input logic [5:0] tl, input logic [5:0] m,
                              input logic [15:0] el, input logic [15:0] er);
        do_mix(s, vp, tl, m);
        wait_done();
        check_val({tag, "_L"}, {16'h0, LEFT_OUT}, {16'h0, el});
        check_val({tag, "_R"}, {16'h0, RIGHT_OUT}, {16'h0, er});
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_val("rst_left", {16'h0, LEFT_OUT}, 32'h0);
        check_val("rst_right", {16'h0, RIGHT_OUT}, 32'h0);
        check_val("rst_valid", {31'h0, OUT_VALID}, 32'h0);
        check_val("rst_busy", {31'h0, BUSY}, 32'h0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        run_expect("full_lvl", 96'h1000, 48'h9F, 6'd63, 6'h01, 16'h1000, 16'h0000);
        run_expect("att1",     96'h1000, 48'h9E, 6'd63, 6'h01, 16'h0EB0, 16'h0000);
        run_expect("att8",     96'h1000, 48'h97, 6'd63, 6'h01, 16'h0800, 16'h0000);
        run_expect("att94",    96'h1000, 48'h80, 6'd0,  6'h01, 16'h0001, 16'h0000);
        run_expect("att94_neg",96'hF000, 48'h80, 6'd0,  6'h01, 16'hFFFE, 16'h0000);
        run_expect("sat_pos", {6{16'h7FFF}}, {6{8'hDF}}, 6'd63, 6'h3F, 16'h7FFF, 16'h7FFF);
        run_expect("sat_neg", {6{16'h8000}}, {6{8'hDF}}, 6'd63, 6'h3F, 16'h8000, 16'h8000);
        run_expect("pan",      {64'h0, 16'hF000, 16'h2000}, {32'h0, 8'h5F, 8'hDF}, 6'd63, 6'h03,
                   16'h2000, 16'h1000);
        run_expect("mask",     {64'h0, 16'hF000, 16'h2000}, {32'h0, 8'h5F, 8'hDF}, 6'd63, 6'h01,
                   16'h2000, 16'h2000);

        // strobe 3 cycles into a mix plus new samples: both must be ignored
        do_mix({64'h0, 16'hF000, 16'h2000}, {32'h0, 8'h5F, 8'hDF}, 6'd63, 6'h03);
        check_val("busy_mid", {31'h0, BUSY}, 32'd1);
        repeat (2) @(negedge CLK);
        CLK_SAMP  = 1'b1;
        SAMPLE_IN = {6{16'h1234}};
        @(negedge CLK);
        CLK_SAMP  = 1'b0;
        wait_done();
        check_val("overlap_L", {16'h0, LEFT_OUT}, 32'h2000);
        check_val("overlap_R", {16'h0, RIGHT_OUT}, 32'h1000);

        // strobe coinciding with the OUT edge is dropped
        do_mix(96'h0400, 48'hDF, 6'd63, 6'h01);
        repeat (7) @(negedge CLK);
        CLK_SAMP = 1'b1;
        @(negedge CLK);
        CLK_SAMP = 1'b0;
        wait_done();
        check_val("out_edge_busy", {31'h0, BUSY}, 32'd0);

        // reset in the middle of a mix
        do_mix(96'h0300, 48'hDF, 6'd63, 6'h01);
        repeat (3) @(negedge CLK);
        #1 RESET = 1'b1;
        sb.delete();
        #1;
        check_val("midrst_left", {16'h0, LEFT_OUT}, 32'h0);
        check_val("midrst_right", {16'h0, RIGHT_OUT}, 32'h0);
        check_val("midrst_busy", {31'h0, BUSY}, 32'h0);
        check_val("midrst_valid", {31'h0, OUT_VALID}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (12) @(negedge CLK);
        run_expect("post_rst", 96'h1000, 48'h9E, 6'd63, 6'h01, 16'h0EB0, 16'h0000);

        for (int k = 0; k < 8; k++) begin
            do_mix({$urandom, $urandom, $urandom}, {$urandom, 16'($urandom)},
                   6'($urandom), 6'($urandom));
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
